// File: rtl/emergency_preempt_controller.sv
// emergency_preempt_controller
//   Fixed-time two-approach (NS/EW) traffic-light sequencer with emergency
//   vehicle preemption. It consumes the ambulance detector's one-cycle pulse
//   and direction tag. It clears the conflicting approach through a full
//   yellow and all-red, then holds green for the ambulance's approach.
//
// Ports
//   clk                 system clock, rising edge
//   reset               asynchronous, active-high reset
//   ambulance_detected  one-cycle detection pulse
//   emerg_dir           ambulance approach, sampled with the pulse (0=NS, 1=EW)
//   ns_light            NS lamps, one-hot {red,yellow,green}
//   ew_light            EW lamps, one-hot {red,yellow,green}
//   emergency_active    request pending or emergency green being held
//   preempt_count       emergency greens served, saturating at 255
//
// State table
//   state        | meaning
//   NS_G         | NS normal green, EW red
//   NS_Y         | NS yellow, never shortened
//   AR_AFTER_NS  | all-red clearance after NS yellow
//   EW_G         | EW normal green, NS red
//   EW_Y         | EW yellow, never shortened
//   AR_AFTER_EW  | all-red clearance after EW yellow
//   EM_NS_G      | emergency green hold for NS
//   EM_EW_G      | emergency green hold for EW

module emergency_preempt_controller #(
    parameter int GREEN_TIME   = 8,
    parameter int YELLOW_TIME  = 3,
    parameter int ALL_RED_TIME = 2,
    parameter int EMERG_TIME   = 10,
    parameter int TIMER_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ambulance_detected,
    input  logic       emerg_dir,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       emergency_active,
    output logic [7:0] preempt_count
);

    typedef enum logic [2:0] {
        NS_G, NS_Y, AR_AFTER_NS, EW_G, EW_Y, AR_AFTER_EW, EM_NS_G, EM_EW_G
    } state_t;

    localparam logic [TIMER_W-1:0] LD_GREEN  = TIMER_W'(GREEN_TIME - 1);
    localparam logic [TIMER_W-1:0] LD_YELLOW = TIMER_W'(YELLOW_TIME - 1);
    localparam logic [TIMER_W-1:0] LD_AR     = TIMER_W'(ALL_RED_TIME - 1);
    localparam logic [TIMER_W-1:0] LD_EMERG  = TIMER_W'(EMERG_TIME - 1);

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    state_t               state, state_next;
    logic [TIMER_W-1:0]   timer;
    logic                 req_valid;
    logic                 req_dir;

    logic                 req_eff;
    logic                 dir_eff;
    logic                 timer_zero;
    logic                 em_reload;
    logic                 in_em;
    logic                 next_em;
    logic                 enter_em;
    logic                 capture;

    function automatic logic [TIMER_W-1:0] phase_load(input state_t s);
        case (s)
            NS_Y, EW_Y:               phase_load = LD_YELLOW;
            AR_AFTER_NS, AR_AFTER_EW: phase_load = LD_AR;
            EM_NS_G, EM_EW_G:         phase_load = LD_EMERG;
            default:                  phase_load = LD_GREEN;
        endcase
    endfunction

    function automatic state_t em_state(input logic dir);
        em_state = dir ? EM_EW_G : EM_NS_G;
    endfunction

    // A pulse arriving this cycle counts as a request immediately, so a pulse
    // on a timer-expiry cycle steers that same transition.
    assign req_eff    = req_valid | ambulance_detected;
    assign dir_eff    = req_valid ? req_dir : emerg_dir;
    assign timer_zero = (timer == '0);

    always_comb begin
        state_next = state;
        em_reload  = 1'b0;
        case (state)
            NS_G: begin
                if (req_eff)         state_next = dir_eff ? NS_Y : EM_NS_G;
                else if (timer_zero) state_next = NS_Y;
            end
            NS_Y: begin
                if (timer_zero) state_next = AR_AFTER_NS;
            end
            AR_AFTER_NS: begin
                if (timer_zero) state_next = req_eff ? em_state(dir_eff) : EW_G;
            end
            EW_G: begin
                if (req_eff)         state_next = dir_eff ? EM_EW_G : EW_Y;
                else if (timer_zero) state_next = EW_Y;
            end
            EW_Y: begin
                if (timer_zero) state_next = AR_AFTER_EW;
            end
            AR_AFTER_EW: begin
                if (timer_zero) state_next = req_eff ? em_state(dir_eff) : NS_G;
            end
            EM_NS_G: begin
                // Same-approach pulse extends the hold, even on the expiry cycle.
                if (ambulance_detected && !emerg_dir) em_reload  = 1'b1;
                else if (timer_zero)                  state_next = NS_Y;
            end
            EM_EW_G: begin
                if (ambulance_detected && emerg_dir) em_reload  = 1'b1;
                else if (timer_zero)                 state_next = EW_Y;
            end
            default: state_next = NS_G;
        endcase
    end

    assign in_em    = (state == EM_NS_G) || (state == EM_EW_G);
    assign next_em  = (state_next == EM_NS_G) || (state_next == EM_EW_G);
    assign enter_em = next_em && !in_em;

    // A pulse becomes pending unless it is being served right now or merely
    // extends the current emergency hold.
    assign capture = ambulance_detected && !req_valid && !enter_em && !em_reload;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= NS_G;
            timer         <= LD_GREEN;
            req_valid     <= 1'b0;
            req_dir       <= 1'b0;
            preempt_count <= 8'd0;
        end else begin
            state <= state_next;

            if ((state_next != state) || em_reload) begin
                timer <= phase_load(state_next);
            end else if (!timer_zero) begin
                timer <= timer - 1'b1;
            end

            if (enter_em) begin
                req_valid <= 1'b0;
            end else if (capture) begin
                req_valid <= 1'b1;
                req_dir   <= emerg_dir;
            end

            if (enter_em && (preempt_count != 8'hFF)) begin
                preempt_count <= preempt_count + 8'd1;
            end
        end
    end

    always_comb begin
        ns_light = LAMP_RED;
        ew_light = LAMP_RED;
        case (state)
            NS_G, EM_NS_G: ns_light = LAMP_GREEN;
            NS_Y:          ns_light = LAMP_YELLOW;
            EW_G, EM_EW_G: ew_light = LAMP_GREEN;
            EW_Y:          ew_light = LAMP_YELLOW;
            default: begin
                ns_light = LAMP_RED;
                ew_light = LAMP_RED;
            end
        endcase
    end

    assign emergency_active = req_valid | in_em;

endmodule

// File: tb/tb_emergency_preempt_controller.sv
module tb_emergency_preempt_controller;

    localparam int G  = 8;
    localparam int Y  = 3;
    localparam int AR = 2;
    localparam int EM = 10;

    logic       clk;
    logic       reset;
    logic       ambulance_detected;
    logic       emerg_dir;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       emergency_active;
    logic [7:0] preempt_count;

    int errors = 0;
    int checks = 0;

    emergency_preempt_controller #(
        .GREEN_TIME(G), .YELLOW_TIME(Y), .ALL_RED_TIME(AR),
        .EMERG_TIME(EM), .TIMER_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ambulance_detected(ambulance_detected),
        .emerg_dir(emerg_dir),
        .ns_light(ns_light),
        .ew_light(ew_light),
        .emergency_active(emergency_active),
        .preempt_count(preempt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int ns, input int ew, input int ea, input int cnt);
        chk({tag, ".ns"},  int'(ns_light), ns);
        chk({tag, ".ew"},  int'(ew_light), ew);
        chk({tag, ".ea"},  int'(emergency_active), ea);
        chk({tag, ".cnt"}, int'(preempt_count), cnt);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit   pulse;
        bit   dir;
        int   n;
        int   ns;
        int   ew;
        int   ea;
        int   cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit p, input bit d, input int n, input int ns, input int ew,
                       input int ea, input int cnt);
        vec_t v;
        v.pulse = p; v.dir = d; v.n = n; v.ns = ns; v.ew = ew; v.ea = ea; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    // ---------------- behavioural reference ----------------
    // A phase is (kind, approach) with an elapsed-cycle count; pending
    // requests live in a queue holding at most one direction.
    localparam int K_G = 0, K_Y = 1, K_AR = 2, K_EM = 3;
    int m_kind;
    bit m_appr;
    int m_el;
    int m_cnt;
    bit m_q[$];

    function automatic int dur(input int k);
        case (k)
            K_G:     return G;
            K_Y:     return Y;
            K_AR:    return AR;
            default: return EM;
        endcase
    endfunction

    task automatic m_reset();
        m_kind = K_G; m_appr = 1'b0; m_el = 0; m_cnt = 0; m_q.delete();
    endtask

    task automatic m_enter(input int k, input bit a);
        m_kind = k; m_appr = a; m_el = 0;
    endtask

    task automatic m_enter_em(input bit a);
        m_q.delete();
        m_enter(K_EM, a);
        if (m_cnt < 255) m_cnt++;
    endtask

    task automatic m_capture(input bit p, input bit d);
        if (p && m_q.size() == 0) m_q.push_back(d);
    endtask

    task automatic m_step(input bit p, input bit d);
        bit req, rdir, last;
        req  = (m_q.size() != 0) || p;
        rdir = (m_q.size() != 0) ? m_q[0] : d;
        last = (m_el == dur(m_kind) - 1);
        case (m_kind)
            K_G: begin
                if (req && rdir == m_appr) m_enter_em(m_appr);
                else if (req) begin m_capture(p, d); m_enter(K_Y, m_appr); end
                else if (last) m_enter(K_Y, m_appr);
                else m_el++;
            end
            K_Y: begin
                m_capture(p, d);
                if (last) m_enter(K_AR, m_appr); else m_el++;
            end
            K_AR: begin
                if (last && req) m_enter_em(rdir);
                else begin
                    m_capture(p, d);
                    if (last) m_enter(K_G, !m_appr); else m_el++;
                end
            end
            default: begin
                if (p && d == m_appr) m_el = 0;
                else begin
                    m_capture(p, d);
                    if (last) m_enter(K_Y, m_appr); else m_el++;
                end
            end
        endcase
    endtask

    function automatic int m_ns();
        if (m_kind == K_AR || m_appr) return 3'b100;
        return (m_kind == K_Y) ? 3'b010 : 3'b001;
    endfunction

    function automatic int m_ew();
        if (m_kind == K_AR || !m_appr) return 3'b100;
        return (m_kind == K_Y) ? 3'b010 : 3'b001;
    endfunction

    function automatic int m_ea();
        return ((m_q.size() != 0) || (m_kind == K_EM)) ? 1 : 0;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bit got;
        bit p, d;

        reset = 1'b1;
        ambulance_detected = 1'b0;
        emerg_dir = 1'b0;
        repeat (2) @(negedge clk);
        chk_all("in_reset", 3'b001, 3'b100, 0, 0);
        reset = 1'b0;

        // {pulse, dir, cycles, ns, ew, ea, count}; pulse is on the first cycle
        add(0,0,2, 3'b001,3'b100,0,0);
        add(1,1,1, 3'b001,3'b100,0,0);   // EW request during NS green
        add(0,0,3, 3'b010,3'b100,1,0);
        add(0,0,2, 3'b100,3'b100,1,0);
        add(0,0,10,3'b100,3'b001,1,1);   // EM_EW_G
        add(0,0,3, 3'b100,3'b010,0,1);
        add(0,0,2, 3'b100,3'b100,0,1);
        add(0,0,8, 3'b001,3'b100,0,1);   // fairness: NS normal green
        add(0,0,3, 3'b010,3'b100,0,1);
        add(0,0,2, 3'b100,3'b100,0,1);
        add(0,0,8, 3'b100,3'b001,0,1);
        add(1,0,1, 3'b100,3'b010,0,1);   // pulse during EW yellow
        add(0,0,2, 3'b100,3'b010,1,1);   // yellow still 3 cycles
        add(0,0,2, 3'b100,3'b100,1,1);
        add(0,0,10,3'b001,3'b100,1,2);   // EM_NS_G
        add(0,0,3, 3'b010,3'b100,0,2);
        add(0,0,2, 3'b100,3'b100,0,2);
        add(0,0,8, 3'b100,3'b001,0,2);   // fairness: EW green
        add(0,0,3, 3'b100,3'b010,0,2);
        add(0,0,2, 3'b100,3'b100,0,2);
        add(0,0,8, 3'b001,3'b100,0,2);
        add(0,0,3, 3'b010,3'b100,0,2);
        add(0,0,1, 3'b100,3'b100,0,2);
        add(1,0,1, 3'b100,3'b100,0,2);   // pulse on all-red expiry
        add(0,0,7, 3'b001,3'b100,1,3);   // EM_NS_G, not EW_G
        add(1,0,1, 3'b001,3'b100,1,3);   // same-dir pulse at timer=2
        add(0,0,10,3'b001,3'b100,1,3);   // hold reloaded, no increment
        add(0,0,3, 3'b010,3'b100,0,3);
        add(0,0,2, 3'b100,3'b100,0,3);
        add(0,0,3, 3'b100,3'b001,0,3);
        add(1,1,1, 3'b100,3'b001,0,3);   // same-dir pulse in EW green
        add(0,0,4, 3'b100,3'b001,1,4);
        add(1,0,1, 3'b100,3'b001,1,4);   // other-dir pulse during hold
        add(0,0,5, 3'b100,3'b001,1,4);
        add(0,0,3, 3'b100,3'b010,1,4);
        add(0,0,2, 3'b100,3'b100,1,4);
        add(0,0,10,3'b001,3'b100,1,5);
        add(0,0,3, 3'b010,3'b100,0,5);
        add(0,0,2, 3'b100,3'b100,0,5);
        add(0,0,2, 3'b100,3'b001,0,5);

        for (int r = 0; r < tbl.size(); r++) begin
            for (int j = 0; j < tbl[r].n; j++) begin
                chk_all($sformatf("vec%0d.%0d", r, j), tbl[r].ns, tbl[r].ew, tbl[r].ea, tbl[r].cnt);
                ambulance_detected = (j == 0) ? tbl[r].pulse : 1'b0;
                emerg_dir          = (j == 0) ? tbl[r].dir   : 1'b0;
                @(negedge clk);
            end
        end

        // Reset in the middle of EM_EW_G with an NS request pending
        ambulance_detected = 1'b1; emerg_dir = 1'b1;
        @(negedge clk);
        ambulance_detected = 1'b1; emerg_dir = 1'b0;
        chk_all("em_ew_entry", 3'b100, 3'b001, 1, 6);
        @(negedge clk);
        ambulance_detected = 1'b0;
        chk_all("em_ew_pending", 3'b100, 3'b001, 1, 6);
        #2 reset = 1'b1;
        #1 chk_all("async_reset", 3'b001, 3'b100, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int j = 0; j < G; j++) begin
            chk_all($sformatf("post_reset_g%0d", j), 3'b001, 3'b100, 0, 0);
            @(negedge clk);
        end
        chk_all("post_reset_y", 3'b010, 3'b100, 0, 0);

        // Saturation: one preemption per pulse, 260 pulses
        for (int i = 0; i < 260; i++) begin
            ambulance_detected = 1'b1;
            emerg_dir = i[0];
            @(negedge clk);
            ambulance_detected = 1'b0;
            got = 1'b0;
            for (int k = 0; k < 60; k++) begin
                if (!emergency_active) begin got = 1'b1; break; end
                @(negedge clk);
            end
            if (!got) begin
                chk("sat_timeout", 0, 1);
                break;
            end
            if (i == 99)  chk("count_100", int'(preempt_count), 100);
            if (i == 254) chk("count_255", int'(preempt_count), 255);
        end
        chk("count_saturated", int'(preempt_count), 255);

        // Randomized run against the reference model
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_reset();
        for (int c = 0; c < 3000; c++) begin
            chk_all($sformatf("rand%0d", c), m_ns(), m_ew(), m_ea(), m_cnt);
            p = ($urandom_range(0, 9) == 0);
            d = 1'($urandom_range(0, 1));
            ambulance_detected = p;
            emerg_dir = d;
            m_step(p, d);
            @(negedge clk);
        end
        ambulance_detected = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
